// File: rtl/psum_accum_requant.sv
// Partial-sum accumulator: sums NUM_TILES beats per lane, then
// requantizes (shift, round, ReLU, saturate) onto a valid/ready port.
module psum_accum_requant #(
    parameter int PARTIAL_SUM_BW = 20,
    parameter int MATRIX_SIZE    = 8,
    parameter int NUM_TILES      = 8,
    parameter int ACC_BW         = 23,
    parameter int OUT_BW         = 8,
    parameter int SHIFT_BW       = 5,
    localparam int CNT_BW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] in_psum,
    input  logic [SHIFT_BW-1:0]               shift,
    input  logic                              relu_en,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [MATRIX_SIZE*OUT_BW-1:0]     out_data,
    output logic [MATRIX_SIZE-1:0]            out_sat,
    output logic [CNT_BW-1:0]                 tile_cnt
);

    localparam int PW = PARTIAL_SUM_BW;
    localparam logic signed [ACC_BW:0] RND_ONE = 1;
    localparam logic signed [ACC_BW:0] OMAX = (2 ** (OUT_BW - 1)) - 1;
    localparam logic signed [ACC_BW:0] OMIN = -(2 ** (OUT_BW - 1));
    localparam logic [CNT_BW-1:0] LAST_CNT = CNT_BW'(NUM_TILES - 1);

    logic signed [ACC_BW-1:0] acc_q [MATRIX_SIZE];
    logic signed [ACC_BW-1:0] acc_d [MATRIX_SIZE];
    logic signed [ACC_BW-1:0] sum   [MATRIX_SIZE];
    logic signed [ACC_BW:0]   rq    [MATRIX_SIZE];

    logic [CNT_BW-1:0]             cnt_q, cnt_d;
    logic                          out_valid_q, out_valid_d;
    logic [MATRIX_SIZE*OUT_BW-1:0] out_data_q, out_data_d;
    logic [MATRIX_SIZE-1:0]        out_sat_q, out_sat_d;
    logic [MATRIX_SIZE*OUT_BW-1:0] req_data;
    logic [MATRIX_SIZE-1:0]        req_sat;

    logic accept;
    logic first;
    logic last;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign first     = (cnt_q == '0);
    assign last      = (cnt_q == LAST_CNT);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign tile_cnt  = cnt_q;

    // Per-lane running sum including the current beat (load on first beat).
    always_comb begin
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            sum[i] = (first ? '0 : acc_q[i])
                   + {{(ACC_BW - PW){in_psum[i*PW + PW - 1]}},
                      in_psum[i*PW +: PW]};
        end
    end

    // Requantize the full sum: round-half-up shift, ReLU, then saturate.
    always_comb begin
        req_data = '0;
        req_sat  = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            rq[i] = {sum[i][ACC_BW-1], sum[i]};
            if (shift != '0) begin
                rq[i] = (rq[i] + (RND_ONE <<< (shift - SHIFT_BW'(1))))
                        >>> shift;
            end
            if (relu_en && rq[i][ACC_BW]) begin
                rq[i] = '0;
            end
            if (rq[i] > OMAX) begin
                rq[i]      = OMAX;
                req_sat[i] = 1'b1;
            end else if (rq[i] < OMIN) begin
                rq[i]      = OMIN;
                req_sat[i] = 1'b1;
            end
            req_data[i*OUT_BW +: OUT_BW] = rq[i][OUT_BW-1:0];
        end
    end

    // Next state: accumulate accepted beats, publish result on final beat.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            acc_d = sum;
            if (last) begin
                cnt_d       = '0;
                out_valid_d = 1'b1;
                out_data_d  = req_data;
                out_sat_d   = req_sat;
            end else begin
                cnt_d = cnt_q + CNT_BW'(1);
            end
        end
    end

    // State registers with synchronous reset that discards a partial group.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MATRIX_SIZE; i++) begin
                acc_q[i] <= '0;
            end
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_psum_accum_requant.sv
// Testbench for psum_accum_requant: directed cases plus randomized
// traffic checked against a group-level arithmetic reference model.
module tb_psum_accum_requant;

    localparam int PW = 20;
    localparam int MS = 8;
    localparam int NT = 8;
    localparam int AB = 23;
    localparam int OB = 8;
    localparam int SB = 5;
    localparam int PMAX = (1 << (PW - 1)) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [MS*PW-1:0]  in_psum = '0;
    logic [SB-1:0]     shift = '0;
    logic              relu_en = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [MS*OB-1:0]  out_data;
    logic [MS-1:0]     out_sat;
    logic [2:0]        tile_cnt;

    psum_accum_requant #(
        .PARTIAL_SUM_BW(PW), .MATRIX_SIZE(MS), .NUM_TILES(NT),
        .ACC_BW(AB), .OUT_BW(OB), .SHIFT_BW(SB)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
        .shift(shift), .relu_en(relu_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: group sums as plain integers.
    longint      m_sum [MS];
    int          m_beats;
    bit          m_ov;
    logic [63:0] m_data;
    logic [7:0]  m_sat;
    int          m_res;
    int          lanes [MS];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic longint floor_div(input longint x, input longint d);
        longint q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    task automatic requant(input longint s, input int sh, input bit relu,
                           output int r, output bit sat);
        longint t;
        t = (sh == 0) ? s : floor_div(s + (longint'(1) << (sh - 1)),
                                      longint'(1) << sh);
        if (relu && t < 0) t = 0;
        sat = 1'b0;
        if (t > 127) begin t = 127; sat = 1'b1; end
        if (t < -128) begin t = -128; sat = 1'b1; end
        r = int'(t);
    endtask

    function automatic logic [MS*PW-1:0] pack();
        logic [MS*PW-1:0] p;
        for (int i = 0; i < MS; i++) p[i*PW +: PW] = lanes[i][PW-1:0];
        return p;
    endfunction

    task automatic set_all(input int v);
        for (int i = 0; i < MS; i++) lanes[i] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < MS; i++) m_sum[i] = 0;
        m_beats = 0;
        m_ov    = 1'b0;
        m_data  = '0;
        m_sat   = '0;
    endtask

    task automatic cycle(input bit v, input int sh, input bit relu,
                         input bit ordy);
        bit m_rdy;
        bit take;
        int r;
        bit s;
        in_valid  = v;
        in_psum   = pack();
        shift     = sh[SB-1:0];
        relu_en   = relu;
        out_ready = ordy;
        #1;
        m_rdy = !m_ov || ordy;
        check("in_ready", in_ready, m_rdy);
        take = v && m_rdy;
        @(posedge clk);
        if (m_ov && ordy) m_ov = 1'b0;
        if (take) begin
            if (m_beats == 0) for (int i = 0; i < MS; i++) m_sum[i] = 0;
            for (int i = 0; i < MS; i++) m_sum[i] += lanes[i];
            m_beats++;
            if (m_beats == NT) begin
                m_beats = 0;
                m_ov = 1'b1;
                m_res++;
                for (int i = 0; i < MS; i++) begin
                    requant(m_sum[i], sh, relu, r, s);
                    m_data[i*8 +: 8] = r[7:0];
                    m_sat[i] = s;
                end
            end
        end
        #1;
        check("out_valid", out_valid, m_ov);
        check("tile_cnt", tile_cnt, m_beats);
        if (m_ov) begin
            check("out_data", out_data, m_data);
            check("out_sat", out_sat, m_sat);
        end
    endtask

    task automatic do_reset(input bit v);
        rst = 1'b1;
        in_valid = v;
        in_psum = pack();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_tile_cnt", tile_cnt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
    endtask

    task automatic group(input int sh, input bit relu);
        for (int b = 0; b < NT; b++) cycle(1'b1, sh, relu, 1'b1);
    endtask

    initial begin
        int cyc;
        int target;
        m_res = 0;
        set_all(0);
        model_reset();
        #2;
        do_reset(1'b0);

        // Saturating positive sums
        set_all(100);
        group(0, 1'b0);
        check("t1_data", out_data, 64'h7f7f7f7f7f7f7f7f);
        check("t1_sat", out_sat, 8'hff);

        // Rounding with opposite signs
        set_all(0); lanes[0] = 3; lanes[1] = -3;
        group(2, 1'b0);
        check("t2_data", out_data, 64'h000000000000fa06);
        check("t2_sat", out_sat, 8'h00);

        // Half rounds up
        set_all(0); lanes[0] = 1;
        group(4, 1'b0);
        check("t2b_data", out_data, 64'h0000000000000001);

        // ReLU before saturation
        set_all(0); lanes[0] = -5; lanes[1] = -625;
        group(0, 1'b1);
        check("t3_data", out_data, 64'h0);
        check("t3_sat", out_sat, 8'h00);

        // Output stall holds data and blocks input
        set_all(10);
        group(0, 1'b0);
        set_all(15);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 0, 1'b0, 1'b0);
            check("stall_ready", in_ready, 0);
            check("stall_hold", out_data, 64'h5050505050505050);
        end
        group(0, 1'b0);
        check("t4_data", out_data, 64'h7878787878787878);
        check("t4_sat", out_sat, 8'h00);

        // Reset aborts a partial group
        set_all(50);
        for (int k = 0; k < 5; k++) cycle(1'b1, 0, 1'b0, 1'b1);
        do_reset(1'b1);
        set_all(1);
        group(0, 1'b0);
        check("t5_data", out_data, 64'h0808080808080808);

        // Randomized traffic with extreme values
        target = m_res + 100;
        cyc = 0;
        while (m_res < target && cyc < 20000) begin
            for (int i = 0; i < MS; i++) begin
                case ($urandom_range(0, 3))
                    0: lanes[i] = PMAX;
                    1: lanes[i] = -PMAX;
                    default:
                        lanes[i] = int'($urandom_range(0, 2 * PMAX)) - PMAX;
                endcase
            end
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, AB - 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            cyc++;
        end
        check("rand_groups_done", m_res >= target, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
